secded_stream_encoder: RTL and testbench
========================================

// Module: secded_stream_encoder
// PURPOSE
//  Pipelined SEC-DED (extended Hamming) encoder; successor to the combinational size-select encoder.
//  Accepts one data word per cycle on a valid/ready stream, with a per-word codeword mode.
//  Emits right-justified codewords {data, parity} to the downstream channel/decoder path.
//  Counts encoded words and flags illegal modes.
// PARAMETERS
//  AMBA_WORD   32  width of in_data/out_data; must be >= 32
//  CNT_WIDTH   16  width of word_cnt
// PORTS
//  clk       in   1          clock, rising edge
//  rst       in   1          asynchronous, active-low reset
//  in_valid  in   1          upstream word valid
//  in_ready  out  1          block can accept word this cycle
//  in_data   in   AMBA_WORD  data word; only low K(mode) bits used
//  in_mode   in   2          0=8b cw (K=4,R=4), 1=16b (K=11,R=5), 2=32b (K=26,R=6), 3=illegal
//  out_valid out  1          codeword valid
//  out_ready in   1          downstream accepts codeword
//  out_data  out  AMBA_WORD  codeword, zero-extended above bit K+R-1
//  out_mode  out  2          mode of the word on out_data
//  err_mode  out  1          1-cycle pulse: illegal-mode word was dropped
//  cnt_clr   in   1          synchronous clear of word_cnt
//  word_cnt  out  CNT_WIDTH  codewords delivered (saturating)
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, out_data=0, out_mode=0, err_mode=0, word_cnt=0; stage valids cleared.
//   in_ready=1 after reset. In-flight words are discarded, not replayed.
//  Parity: d = in_data[K-1:0]. Column H(i) for d[i] = i-th integer >=3 (ascending) that is not a power of 2
//   (3,5,6,7,9,10,...). p[j] = XOR of d[i] with H(i)[j]=1, j=0..R-2.
//   p[R-1] = XOR of all d bits and p[R-2:0] (overall parity).
//   out_data = {zeros, d[K-1:0], p[R-1:0]}.
//  Pipeline: S1 registers masked data+mode; S2 registers codeword+mode (S2 = output regs).
//   Latency 2 cycles in_valid&in_ready -> out_valid with out_ready held 1; throughput 1 word/cycle.
//  Handshake: transfer when valid&ready on the same edge. out_data/out_mode/out_valid stable while
//   out_valid=1 and out_ready=0. S2 loads when empty or out_ready=1; S1 loads when empty or S1 moves to S2.
//   in_ready = !S1_valid | S1 advancing (combinational path from out_ready allowed).
//  Backpressure: both stages full and out_ready=0 -> in_ready=0; no word lost or duplicated.
//  Illegal mode (3): word accepted normally (in_ready honoured), never enters S2 nor reaches output.
//   err_mode=1 the cycle after acceptance; back-to-back illegal words -> err_mode held high.
//  word_cnt: +1 on each out_valid&out_ready; saturates at all-ones. cnt_clr has priority over
//   increment in the same cycle (result 0).
//  Mode changes word-by-word with no bubbles; bits of in_data above K ignored.
// TESTING
//  mode0, in_data=32'h1 -> after 2 cycles out_data=32'h0000001B, out_mode=0, word_cnt=1.
//  mode0, in_data=32'hF -> out_data=32'h000000FF; in_data=32'hFFFFFFF0 -> out_data=32'h00000000.
//  Stream 8 words alternating modes 0/1/2 with out_ready=1 -> 8 outputs, 1/cycle, order and mode
//   preserved; each codeword matches the H(i) reference model; single-bit flip gives a nonzero syndrome.
//  out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts; out_data stable;
//   release -> all words delivered once, in order.
//  in_mode=3 between two legal words -> err_mode pulses 1 cycle; only 2 codewords out; word_cnt=2.
//  Assert rst mid-stream with out_valid=1 -> out_valid=0, word_cnt=0 immediately; cnt_clr with
//   handshake same cycle -> word_cnt=0.

Source files
------------

// File: rtl/secded_stream_encoder.sv
// rtl/secded_stream_encoder.sv - two-stage pipelined SEC-DED (extended Hamming) stream encoder
module secded_stream_encoder #(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] out_data,
    output logic [1:0]           out_mode,
    output logic                 err_mode,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    // Build the codeword from already-masked data. Column for d[i] walks the
    // integers from 3 upward, skipping powers of two; data bits above K are
    // zero so they contribute nothing and the upper parity bits stay zero.
    function automatic logic [31:0] encode(input logic [25:0] d, input logic [1:0] mode);
        logic [4:0]  p;
        logic [4:0]  col;
        logic        ov;
        logic [31:0] cw;
        p   = '0;
        col = 5'd3;
        for (int i = 0; i < 26; i++) begin
            if (d[i]) begin
                p = p ^ col;
            end
            col = col + 5'd1;
            if ((col & (col - 5'd1)) == 5'd0) begin
                col = col + 5'd1;
            end
        end
        ov = (^d) ^ (^p);
        case (mode)
            2'd0:    cw = {24'd0, d[3:0], ov, p[2:0]};
            2'd1:    cw = {16'd0, d[10:0], ov, p[3:0]};
            default: cw = {d[25:0], ov, p[4:0]};
        endcase
        return cw;
    endfunction

    logic                 s1_valid_q;
    logic [25:0]          s1_data_q;
    logic [1:0]           s1_mode_q;
    logic                 out_valid_q;
    logic [AMBA_WORD-1:0] out_data_q;
    logic [1:0]           out_mode_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic        s2_ready;
    logic        s1_adv;
    logic        accept;
    logic        accept_legal;
    logic [25:0] in_masked;
    logic [31:0] s1_cw;
    logic        unused_in_bits;

    assign unused_in_bits = ^in_data[AMBA_WORD-1:26];

    // Handshake: S2 frees when empty or draining; S1 frees when it advances.
    assign s2_ready     = !out_valid_q || out_ready;
    assign s1_adv       = s1_valid_q && s2_ready;
    assign in_ready     = !s1_valid_q || s1_adv;
    assign accept       = in_valid && in_ready;
    assign accept_legal = accept && (in_mode != MODE_ILLEGAL);

    // Keep only the K data bits selected by the word's mode.
    always_comb begin
        in_masked = '0;
        case (in_mode)
            2'd0:    in_masked[3:0]  = in_data[3:0];
            2'd1:    in_masked[10:0] = in_data[10:0];
            default: in_masked       = in_data[25:0];
        endcase
    end

    // Parity generation sits between S1 and S2.
    always_comb begin
        s1_cw = encode(s1_data_q, s1_mode_q);
    end

    // S1: illegal-mode words are accepted but never occupy the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 2'd0;
        end else if (accept_legal) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= in_masked;
            s1_mode_q  <= in_mode;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2 output registers: hold the codeword stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 2'd0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            out_data_q  <= AMBA_WORD'(s1_cw);
            out_mode_q  <= s1_mode_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Illegal-mode flag: one pulse per dropped word, the cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (in_mode == MODE_ILLEGAL);
        end
    end

    // Delivered-word counter next state: clear wins, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Delivered-word counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign err_mode  = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_secded_stream_encoder.sv
// tb/tb_secded_stream_encoder.sv - scoreboard bench for secded_stream_encoder
module tb_secded_stream_encoder;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic [1:0]    out_mode;
    logic          err_mode;
    logic          cnt_clr;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    secded_stream_encoder #(.AMBA_WORD(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .err_mode(err_mode), .cnt_clr(cnt_clr), .word_cnt(word_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int k_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 11 : 26;
    endfunction

    function automatic int r_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
    endfunction

    function automatic logic [4:0] col_of(input int idx);
        int n;
        int c;
        n = 2;
        c = -1;
        while (c < idx) begin
            n++;
            if ((n & (n - 1)) != 0) c++;
        end
        return n[4:0];
    endfunction

    function automatic logic [31:0] ref_cw(input logic [31:0] d, input logic [1:0] m);
        int k;
        int r;
        logic [31:0] cw;
        logic [4:0] c;
        logic b;
        k = k_of(m);
        r = r_of(m);
        cw = '0;
        for (int i = 0; i < k; i++) cw[r+i] = d[i];
        for (int j = 0; j < r - 1; j++) begin
            b = 1'b0;
            for (int i = 0; i < k; i++) begin
                c = col_of(i);
                b = b ^ (d[i] & c[j]);
            end
            cw[j] = b;
        end
        cw[r-1] = ^cw;
        return cw;
    endfunction

    function automatic logic [5:0] syndrome(input logic [31:0] cw, input logic [1:0] m);
        int k;
        int r;
        logic [5:0] s;
        logic [4:0] c;
        logic b;
        k = k_of(m);
        r = r_of(m);
        s = '0;
        for (int j = 0; j < r - 1; j++) begin
            b = cw[j];
            for (int i = 0; i < k; i++) begin
                c = col_of(i);
                b = b ^ (cw[r+i] & c[j]);
            end
            s[j] = b;
        end
        b = 1'b0;
        for (int i = 0; i < k + r; i++) b = b ^ cw[i];
        s[5] = b;
        return s;
    endfunction

    logic [33:0]   exp_q[$];
    logic [33:0]   e;
    logic [CW-1:0] exp_cnt = '0;
    logic          err_pend = 1'b0;
    int            out_cnt = 0;
    int            err_hi = 0;
    logic [31:0]   flipped;
    int            pos;

    // Scoreboard: push on accepted legal input, pop and compare on delivery.
    always @(negedge clk) begin
        if (!rst) begin
            err_pend = 1'b0;
            exp_cnt  = '0;
            exp_q.delete();
        end else begin
            check_eq("err_mode", err_mode, err_pend);
            check_eq("word_cnt", word_cnt, exp_cnt);
            if (err_mode) err_hi++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e[31:0]);
                    check_eq("out_mode", out_mode, e[33:32]);
                    pos = $urandom_range(0, k_of(e[33:32]) + r_of(e[33:32]) - 1);
                    flipped = out_data ^ (32'h1 << pos);
                    check_eq("syndrome_nz", syndrome(flipped, e[33:32]) != 6'd0, 1);
                end
                out_cnt++;
            end else if (out_valid && exp_q.size() > 0) begin
                check_eq("stall_data", out_data, exp_q[0][31:0]);
                check_eq("stall_mode", out_mode, exp_q[0][33:32]);
            end
            if (cnt_clr) exp_cnt = '0;
            else if (out_valid && out_ready && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            err_pend = in_valid && in_ready && (in_mode == 2'd3);
            if (in_valid && in_ready && in_mode != 2'd3)
                exp_q.push_back({in_mode, ref_cw(in_data, in_mode)});
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check_eq("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic directed(input logic [31:0] d, input logic [1:0] m, input logic [31:0] x, input string tag);
        send(d, m);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_data"}, out_data, x);
        check_eq({tag, "_mode"}, out_mode, m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    logic [31:0] w[4];
    logic [1:0]  wm[4];
    int idx;
    int base;
    logic acc;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_mode", out_mode, 0);
        check_eq("rst_err_mode", err_mode, 0);
        check_eq("rst_word_cnt", word_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        directed(32'h1, 2'd0, 32'h0000001B, "m0_one");
        check_eq("cnt_first", word_cnt, 1);
        directed(32'hF, 2'd0, 32'h000000FF, "m0_f");
        directed(32'hFFFFFFF0, 2'd0, 32'h00000000, "m0_upper");

        base = out_cnt;
        for (int i = 0; i < 8; i++) send($urandom, 2'(i % 3));
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("stream_count", out_cnt - base, 8);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 4; i++) begin
            w[i]  = $urandom;
            wm[i] = 2'($urandom_range(0, 2));
        end
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; in_data = w[0]; in_mode = wm[0];
        repeat (5) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_data = w[idx];
                in_mode = wm[idx];
            end
        end
        @(negedge clk);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_accepts", idx, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) send(w[i], wm[i]);
        in_valid = 1'b0;
        drain();

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        err_hi = 0;
        send($urandom, 2'd0);
        send($urandom, 2'd3);
        send($urandom, 2'd1);
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_eq("illegal_cnt", word_cnt, 2);
        check_eq("illegal_err_cycles", err_hi, 1);
        err_hi = 0;
        send($urandom, 2'd3);
        send($urandom, 2'd3);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("b2b_err_cycles", err_hi, 2);

        for (int i = 0; i < 18; i++) send($urandom, 2'(i % 3));
        in_valid = 1'b0;
        drain();
        check_eq("cnt_saturated", word_cnt, 15);

        out_ready = 1'b0;
        send($urandom, 2'd2);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("clr_pre_valid", out_valid, 1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_eq("clr_with_handshake", word_cnt, 0);
        drain();

        send($urandom, 2'd1);
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send($urandom, 2'd1);
        send($urandom, 2'd2);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_pre_valid", out_valid, 1);
        check_eq("mid_pre_cnt", word_cnt, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_cnt", word_cnt, 0);
        check_eq("mid_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        directed(32'h1, 2'd0, 32'h0000001B, "post_rst");
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
